// File: rtl/return_stack_if.sv
// Bus between the control unit / PC path and the return-address stack.
// The master drives the call/return strobes; the stack returns top-of-stack and status.
interface return_stack_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             wesp;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wesp, push, pop, d_in,
        input  d_out, empty, full, count, overflow, underflow
    );

    modport slave (
        input  wesp, push, pop, d_in,
        output d_out, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack: push on call, zero-latency top-of-stack for return,
// occupancy tracking and sticky overflow/underflow debug flags.
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   SP_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]   SP_ONE  = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_sp;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_top;
    logic [CW-1:0]    w_sp_nxt;
    logic [CW-1:0]    w_wr_idx;
    logic             w_we;
    logic             w_set_ovf;
    logic             w_set_unf;

    // Operation decode; push+pop replaces the top, or acts as a plain push when empty.
    always_comb begin
        w_empty   = (r_sp == {CW{1'b0}});
        w_full    = (r_sp == SP_FULL);
        w_top     = r_sp - SP_ONE;
        w_sp_nxt  = r_sp;
        w_wr_idx  = r_sp;
        w_we      = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (bus.wesp) begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_sp_nxt = r_sp + SP_ONE;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_sp_nxt = w_top;
                    end
                end
                2'b11: begin
                    w_we = 1'b1;
                    if (w_empty) begin
                        w_sp_nxt = r_sp + SP_ONE;
                    end else begin
                        w_wr_idx = w_top;
                    end
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end else begin
            w_we = 1'b0;
        end
    end

    // Stack pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp        <= {CW{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_overflow  <= r_overflow | w_set_ovf;
            r_underflow <= r_underflow | w_set_unf;
        end
    end

    // Entry storage is deliberately not reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_wr_idx[AW-1:0]] <= bus.d_in;
        end
    end

    // Top-of-stack read path: depends only on sp and stored entries.
    always_comb begin
        if (w_empty) begin
            bus.d_out = {WIDTH{1'b0}};
        end else begin
            bus.d_out = r_mem[w_top[AW-1:0]];
        end
    end

    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_sp;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: a queue-based reference model feeds a scoreboard
// of expected observations that are compared against the DUT away from the clock edge.
module tb_return_stack;
    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;

    return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        bit               dout_only;
        logic [WIDTH-1:0] dout;
        logic [CW-1:0]    cnt;
        logic             emp;
        logic             ful;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] m_stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    int               n_tests = 0;
    int               n_fail  = 0;

    function automatic logic [WIDTH-1:0] model_top();
        if (m_stk.size() == 0) return {WIDTH{1'b0}};
        return m_stk[m_stk.size() - 1];
    endfunction

    task automatic expect_state(input string tag);
        exp_t e;
        e.tag       = tag;
        e.dout_only = 1'b0;
        e.dout      = model_top();
        e.cnt       = CW'(m_stk.size());
        e.emp       = (m_stk.size() == 0);
        e.ful       = (m_stk.size() == DEPTH);
        e.ovf       = m_ovf;
        e.unf       = m_unf;
        sb.push_back(e);
    endtask

    task automatic expect_top(input string tag);
        exp_t e;
        e.tag       = tag;
        e.dout_only = 1'b1;
        e.dout      = model_top();
        e.cnt       = '0;
        e.emp       = 1'b0;
        e.ful       = 1'b0;
        e.ovf       = 1'b0;
        e.unf       = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            assert (bus.d_out === e.dout) else begin
                n_fail++;
                $error("FAIL %s d_out got %h exp %h", e.tag, bus.d_out, e.dout);
            end
            if (!e.dout_only) begin
                n_tests++;
                assert (bus.count === e.cnt) else begin
                    n_fail++;
                    $error("FAIL %s count got %0d exp %0d", e.tag, bus.count, e.cnt);
                end
                n_tests++;
                assert ({bus.empty, bus.full} === {e.emp, e.ful}) else begin
                    n_fail++;
                    $error("FAIL %s empty/full got %b%b exp %b%b", e.tag,
                           bus.empty, bus.full, e.emp, e.ful);
                end
                n_tests++;
                assert ({bus.overflow, bus.underflow} === {e.ovf, e.unf}) else begin
                    n_fail++;
                    $error("FAIL %s ovf/unf got %b%b exp %b%b", e.tag,
                           bus.overflow, bus.underflow, e.ovf, e.unf);
                end
            end
        end
    endtask

    // One clock: drive inputs, check zero-latency top, update model, check post-edge state.
    task automatic cycle(input string tag, input logic rst, input logic w,
                         input logic pu, input logic po, input logic [WIDTH-1:0] d);
        reset    = rst;
        bus.wesp = w;
        bus.push = pu;
        bus.pop  = po;
        bus.d_in = d;
        #1;
        if (!rst && w && po && m_stk.size() > 0) expect_top({tag, "_pre"});
        check_sb();
        if (rst) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (w) begin
            if (pu && !po) begin
                if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else m_stk.push_back(d);
            end else if (!pu && po) begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else void'(m_stk.pop_back());
            end else if (pu && po) begin
                if (m_stk.size() == 0) m_stk.push_back(d);
                else m_stk[m_stk.size() - 1] = d;
            end
        end
        @(posedge clk);
        @(negedge clk);
        expect_state(tag);
        check_sb();
    endtask

    initial begin
        reset    = 1'b1;
        bus.wesp = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.d_in = '0;

        cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        for (int i = 0; i < 3; i++) cycle("idle_nowesp", 1'b0, 1'b0, 1'b1, 1'b0, 10'h155);
        cycle("idle_nowesp_pop", 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);

        cycle("push_005", 1'b0, 1'b1, 1'b1, 1'b0, 10'h005);
        cycle("push_0a3", 1'b0, 1'b1, 1'b1, 1'b0, 10'h0A3);
        cycle("push_3ff", 1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF);
        for (int i = 0; i < 3; i++) cycle("pop_order", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);

        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b0, 1'b1, 1'b1, 1'b0, WIDTH'(i));
        cycle("overflow_push", 1'b0, 1'b1, 1'b1, 1'b0, 10'h111);
        cycle("pop_after_ovf", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        for (int i = 0; i < DEPTH - 1; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);

        cycle("underflow_pop", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        cycle("push_after_unf", 1'b0, 1'b1, 1'b1, 1'b0, 10'h042);

        cycle("reset2", 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        cycle("push_010", 1'b0, 1'b1, 1'b1, 1'b0, 10'h010);
        cycle("push_020", 1'b0, 1'b1, 1'b1, 1'b0, 10'h020);
        cycle("replace_0ff", 1'b0, 1'b1, 1'b1, 1'b1, 10'h0FF);
        cycle("pop_below_replace", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        cycle("pop_to_empty", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        cycle("pushpop_empty_077", 1'b0, 1'b1, 1'b1, 1'b1, 10'h077);
        cycle("pop_077", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);

        for (int i = 1; i <= DEPTH; i++) cycle("refill", 1'b0, 1'b1, 1'b1, 1'b0, WIDTH'(i + 32));
        cycle("overflow2", 1'b0, 1'b1, 1'b1, 1'b0, 10'h222);
        for (int i = 0; i < DEPTH - 5; i++) cycle("down_to_5", 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        cycle("reset_mid_push", 1'b1, 1'b1, 1'b1, 1'b0, 10'h2AA);
        cycle("idle_after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        cycle("push_after_reset", 1'b0, 1'b1, 1'b1, 1'b0, 10'h1C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack for the single-cycle CPU.
- Sits directly downstream of the control unit and consumes its wesp/push/pop strobes.
- On a call it stores the return address presented by the PC path.
- On a return it supplies the saved address to the next-PC mux in the same cycle, so the PC loads it at the clock edge.
- Tracks occupancy and latches sticky overflow/underflow error flags for debug and I/O status.

Parameters:
- WIDTH, 10, bit width of a stored address (matches PC width).
- DEPTH, 16, number of stack entries; must be >= 2 (power of two not required).
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wesp  input  1  stack write enable from the control unit; push/pop are ignored when 0.
- push  input  1  push request (call).
- pop  input  1  pop request (return).
- d_in  input  WIDTH  return address to store (PC+1 from the PC path).
- d_out  output  WIDTH  current top-of-stack entry; combinational.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- count  output  CW  number of valid entries.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Internal state:
  - sp register, 0..DEPTH; equals count.
  - Entry array mem[0..DEPTH-1], not reset.
- Reset (reset=1 at rising edge):
  - sp=0, overflow=0, underflow=0.
  - Hence count=0, empty=1, full=0, d_out=0.
  - reset has priority over every other input.
  - Any push/pop in the reset cycle is discarded, including mid-sequence.
- Read path:
  - d_out = mem[sp-1] when sp>0; d_out = 0 when sp==0.
  - Zero latency: a pop presented in cycle N shows the popped address on d_out during cycle N.
  - After the edge, d_out shows the new top.
- Operations, evaluated at the rising edge only when wesp=1 and reset=0:
  - push=1, pop=0, not full: mem[sp] <= d_in; sp <= sp+1.
  - push=1, pop=0, full: no write; sp unchanged; overflow <= 1.
  - push=0, pop=1, not empty: sp <= sp-1; entry contents untouched.
  - push=0, pop=1, empty: sp unchanged; underflow <= 1.
  - push=1, pop=1, not empty: replace top, i.e. mem[sp-1] <= d_in; sp unchanged.
  - push=1, pop=1, empty: behaves as a plain push (write mem[0], sp <= 1); no underflow.
  - push=0, pop=0: no change.
- wesp=0: no state change regardless of push/pop.
- Sticky flags:
  - overflow and underflow stay set until reset.
  - They never block later legal operations.
- Boundaries:
  - Push into the last slot (sp=DEPTH-1) succeeds and raises full the following cycle.
  - Pop from sp=1 empties the stack; d_out becomes 0 after the edge.
  - sp never exceeds DEPTH and never wraps below 0.
- Derived outputs:
  - empty, full and count derive from sp only (registered-state based, no input paths).
  - d_out has no path from push/pop/d_in; combinational only through sp and mem.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset 1 cycle, then 3 idle cycles with push=1, wesp=0.
  - Required: count=0, empty=1, full=0, d_out=0, flags 0 throughout.
- Push/pop order:
  - Stimulus: wesp=1; push d_in=0x005, 0x0A3, 0x3FF on consecutive cycles.
  - Required after pushes: count=3, d_out=0x3FF.
  - Stimulus: pop three times.
  - Required: d_out reads 0x3FF, 0x0A3, 0x005 in the pop cycles; then empty=1, d_out=0.
- Fill and overflow (DEPTH=16):
  - Stimulus: push values 1..16, then push 0x111.
  - Required: full=1 after the 16th push; 17th push sets overflow=1, count stays 16, d_out stays 16.
  - Stimulus: then pop once.
  - Required: count=15, d_out=15, overflow remains 1.
- Underflow:
  - Stimulus: pop on empty stack.
  - Required: underflow=1, count=0.
  - Stimulus: subsequent push 0x042.
  - Required: count=1, d_out=0x042, underflow still 1.
- Simultaneous push+pop:
  - Stimulus: with entries 0x010, 0x020, assert push=pop=1, d_in=0x0FF.
  - Required: count=2, d_out=0x0FF, next entry down still 0x010.
  - Stimulus: same on empty stack with d_in=0x077.
  - Required: count=1, d_out=0x077, no flags.
- Reset mid-operation:
  - Stimulus: with count=5 and overflow=1, assert reset together with push=1, wesp=1.
  - Required: next cycle count=0, empty=1, overflow=0, underflow=0, d_out=0; no entry written.
